dodge_action: RTL and testbench

// - Game-step engine for a gs x gs LED-matrix dodging game: a player pixel on a fixed row is

---
 rtl/dodge_action_if.sv | 21 ++
 rtl/dodge_action.sv | 127 ++++++++++++
 tb/tb_dodge_action.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dodge_action_if.sv
// rtl/dodge_action_if.sv - step handshake, steering and display bundle for the dodge game engine
interface dodge_action_if #(
   parameter int gs = 8
);
   logic             left_i;
   logic             right_i;
   logic             e_act_i;
   logic [gs*gs-1:0] matrix_o;
   logic             d_act_o;
   logic             dead_o;

   modport master (
      output left_i, right_i, e_act_i,
      input  matrix_o, d_act_o, dead_o
   );

   modport slave (
      input  left_i, right_i, e_act_i,
      output matrix_o, d_act_o, dead_o
   );
endinterface

// File: rtl/dodge_action.sv
// rtl/dodge_action.sv - dodge game step engine: steer player, scroll obstacles, detect collision
// Optional feature: define ACTION_WRAP_EN to make the player column wrap at the edges
// instead of saturating.
module dodge_action #(
   parameter int              gs          = 8,
   parameter int              cr          = 2,
   parameter int              nr          = 10,
   parameter logic [gs*nr-1:0] data_struct = 80'h40_04_10_01_80_20_02_08_80_04
) (
   input  logic           clk_i,
   input  logic           reset_i,
   dodge_action_if.slave  bus
);
   localparam int cw = (gs > 1) ? $clog2(gs) : 1;
   localparam int pw = (nr > 1) ? $clog2(nr) : 1;

   typedef enum logic [2:0] {IDLE, MOVE, SCROLL, CHECK, DONE} state_t;

   state_t           state;
   logic [gs*gs-1:0] rows;        // obstacle field, same layout as matrix_o
   logic [cw-1:0]    col;
   logic [pw-1:0]    ptr;
   logic             left_flag;
   logic             right_flag;
   logic             skip;        // the IDLE cycle right after DONE ignores e_act_i
   logic             dead;
   logic             d_act;
   logic [gs*gs-1:0] matrix;

   logic             go_left;
   logic             go_right;
   logic [cw-1:0]    col_next;
   logic [gs-1:0]    pat_row;
   logic [gs*gs-1:0] rows_scrolled;

   function automatic logic [gs*gs-1:0] player_mask(input logic [cw-1:0] c);
      logic [gs*gs-1:0] m;
      m = '0;
      m[cr*gs + int'(c)] = 1'b1;
      return m;
   endfunction

   assign pat_row       = data_struct[gs*nr-1 - int'(ptr)*gs -: gs];
   assign rows_scrolled = {pat_row, rows[gs*gs-1:gs]};

   // Column the player moves to in MOVE; a request arriving in MOVE itself still counts.
   always_comb begin
      go_left  = left_flag | bus.left_i;
      go_right = right_flag | bus.right_i;
      col_next = col;
      if (go_left && !go_right) begin
`ifdef ACTION_WRAP_EN
         col_next = (col == cw'(gs-1)) ? '0 : col + 1'b1;
`else
         col_next = (col == cw'(gs-1)) ? col : col + 1'b1;
`endif
      end else if (go_right && !go_left) begin
`ifdef ACTION_WRAP_EN
         col_next = (col == '0) ? cw'(gs-1) : col - 1'b1;
`else
         col_next = (col == '0) ? col : col - 1'b1;
`endif
      end
   end

   // Step sequencer with sticky move flags and registered frame/handshake outputs.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state      <= IDLE;
         rows       <= '0;
         col        <= cw'(gs/2);
         ptr        <= '0;
         left_flag  <= 1'b0;
         right_flag <= 1'b0;
         skip       <= 1'b0;
         dead       <= 1'b0;
         d_act      <= 1'b0;
         matrix     <= player_mask(cw'(gs/2));
      end else begin
         left_flag  <= left_flag | bus.left_i;
         right_flag <= right_flag | bus.right_i;
         d_act      <= 1'b0;
         case (state)
            IDLE: begin
               if (skip) begin
                  skip <= 1'b0;
               end else if (bus.e_act_i) begin
                  state <= MOVE;
               end
            end
            MOVE: begin
               left_flag  <= 1'b0;
               right_flag <= 1'b0;
               if (!dead) begin
                  col    <= col_next;
                  matrix <= rows | player_mask(col_next);
               end
               state <= SCROLL;
            end
            SCROLL: begin
               if (!dead) begin
                  rows   <= rows_scrolled;
                  ptr    <= (ptr == pw'(nr-1)) ? '0 : ptr + 1'b1;
                  matrix <= rows_scrolled | player_mask(col);
               end
               state <= CHECK;
            end
            CHECK: begin
               if (rows[cr*gs + int'(col)]) begin
                  dead <= 1'b1;
               end
               d_act <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               skip  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.matrix_o = matrix;
   assign bus.d_act_o  = d_act;
   assign bus.dead_o   = dead;
endmodule

// File: tb/tb_dodge_action.sv
// tb/tb_dodge_action.sv - directed self-checking bench for dodge_action
module tb_dodge_action;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   dodge_action_if #(.gs(8)) bus ();

   dodge_action dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic do_step(input string tag);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      @(negedge clk);
      bus.e_act_i = 1'b1;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (bus.d_act_o) seen = 1'b1;
      end
      bus.e_act_i = 1'b0;
      check({tag, "_latency"}, seen ? 64'(n) : 64'd999, 64'd4);
      @(negedge clk);
      check({tag, "_pulse_end"}, 64'(bus.d_act_o), 64'd0);
   endtask

   // Directed scenarios; each expected frame is worked out by hand from the obstacle pattern.
   initial begin
      logic [7:0] exp_right [5];
      int         pulses;
      exp_right[0] = 8'h08;
      exp_right[1] = 8'h04;
      exp_right[2] = 8'h02;
      exp_right[3] = 8'h01;
`ifdef ACTION_WRAP_EN
      exp_right[4] = 8'h80;
`else
      exp_right[4] = 8'h01;
`endif
      n_checks    = 0;
      n_pass      = 0;
      reset       = 1'b1;
      bus.left_i  = 1'b0;
      bus.right_i = 1'b0;
      bus.e_act_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_matrix", bus.matrix_o, 64'h0000_0000_0010_0000);
      check("rst_dead", 64'(bus.dead_o), 64'd0);
      check("rst_d_act", 64'(bus.d_act_o), 64'd0);

      do_step("s1");
      check("s1_top_row", 64'(bus.matrix_o[63:56]), 64'h40);
      check("s1_matrix", bus.matrix_o, 64'h4000_0000_0010_0000);

      // one-cycle left pulse between steps
      @(negedge clk);
      bus.left_i = 1'b1;
      @(negedge clk);
      bus.left_i = 1'b0;
      do_step("s2");
      check("left_bit21", 64'(bus.matrix_o[21]), 64'd1);
      check("left_matrix", bus.matrix_o, 64'h0440_0000_0020_0000);

      // right held: saturate (or wrap) at column 0
      do_reset();
      bus.right_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         do_step($sformatf("r%0d", i));
         check($sformatf("right_row%0d", i), 64'(bus.matrix_o[23:16]), 64'(exp_right[i]));
      end
      bus.right_i = 1'b0;

      // reset in SCROLL aborts the step
      do_reset();
      do_step("a1");
      @(negedge clk);
      bus.e_act_i = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset       = 1'b1;
      bus.e_act_i = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("abort_matrix", bus.matrix_o, 64'h0000_0000_0010_0000);
      check("abort_dead", 64'(bus.dead_o), 64'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus.d_act_o) pulses++;
         @(negedge clk);
      end
      check("abort_no_pulse", 64'(pulses), 64'd0);
      do_step("a2");
      check("abort_ptr_reset", bus.matrix_o, 64'h4000_0000_0010_0000);

      // continuous steps until collision at step 8, then frozen
      do_reset();
      for (int i = 1; i <= 7; i++) do_step($sformatf("d%0d", i));
      check("alive_step7", 64'(bus.dead_o), 64'd0);
      do_step("d8");
      check("dead_step8", 64'(bus.dead_o), 64'd1);
      check("dead_matrix", bus.matrix_o, 64'h0802_2080_0110_0440);
      bus.left_i = 1'b1;
      do_step("d9");
      bus.left_i = 1'b0;
      check("frozen_matrix", bus.matrix_o, 64'h0802_2080_0110_0440);
      check("dead_sticky", 64'(bus.dead_o), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
